// File: rtl/fane_mac_pkg.sv
// Shared definitions for the FANE vector MAC: FP8 constants, FSM encoding and FP8 arithmetic helpers.
// FP8 model: exponent field 0 is zero (subnormals flush to zero), no Inf/NaN, overflow saturates, round-to-nearest-even.
package fane_mac_pkg;

    localparam int FP8_W = 8;
    localparam logic [FP8_W-1:0] FP8_ZERO = 8'h00;
    localparam int MUL_LAT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [FP8_W-1:0] fp8_pack(input logic s, input int e, input int keep,
                                                  input int ew, input int mw);
        logic [FP8_W-1:0] r;
        if (e <= 0) return FP8_ZERO;
        if (e > (1 << ew) - 1) return {s, 7'h7f};
        r = 8'((e << mw) | (keep & ((1 << mw) - 1)));
        r[7] = s;
        return r;
    endfunction

    function automatic logic [FP8_W-1:0] fp8_mul(input logic [FP8_W-1:0] a, input logic [FP8_W-1:0] b,
                                                 input int ew, input int mw);
        int ea, eb, fa, fb, e, p, sh, keep, rem;
        ea = int'(a[6:0]) >> mw;
        eb = int'(b[6:0]) >> mw;
        fa = int'(a[6:0]) & ((1 << mw) - 1);
        fb = int'(b[6:0]) & ((1 << mw) - 1);
        if (ea == 0 || eb == 0) return FP8_ZERO;
        p  = ((1 << mw) | fa) * ((1 << mw) | fb);
        e  = ea + eb - ((1 << (ew - 1)) - 1);
        sh = mw;
        if (p >= (1 << (2 * mw + 1))) begin
            sh = mw + 1;
            e++;
        end
        keep = p >> sh;
        rem  = p & ((1 << sh) - 1);
        if (rem > (1 << (sh - 1)) || (rem == (1 << (sh - 1)) && (keep & 1) != 0)) keep++;
        if (keep == (1 << (mw + 1))) begin
            keep = keep >> 1;
            e++;
        end
        return fp8_pack(a[7] ^ b[7], e, keep, ew, mw);
    endfunction

    function automatic logic [FP8_W-1:0] fp8_add(input logic [FP8_W-1:0] a, input logic [FP8_W-1:0] b,
                                                 input int ew, input int mw);
        logic [FP8_W-1:0] x, y;
        int ex, ey, mx, my, e, d, sum, keep, rem;
        if ((int'(a[6:0]) >> mw) == 0) return ((int'(b[6:0]) >> mw) == 0) ? FP8_ZERO : b;
        if ((int'(b[6:0]) >> mw) == 0) return a;
        // Larger magnitude goes to x; exponent sits above mantissa so the raw field compares correctly
        if (b[6:0] > a[6:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        ex = int'(x[6:0]) >> mw;
        ey = int'(y[6:0]) >> mw;
        mx = ((1 << mw) | (int'(x[6:0]) & ((1 << mw) - 1))) << 3;
        my = ((1 << mw) | (int'(y[6:0]) & ((1 << mw) - 1))) << 3;
        d  = ex - ey;
        if (d > mw + 4) my = 1;
        else if (d > 0) my = (my >> d) | (((my & ((1 << d) - 1)) != 0) ? 1 : 0);
        e = ex;
        if (x[7] == y[7]) begin
            sum = mx + my;
            if (sum >= (1 << (mw + 4))) begin
                sum = (sum >> 1) | (sum & 1);
                e++;
            end
        end else begin
            sum = mx - my;
            if (sum == 0) return FP8_ZERO;
            for (int i = 0; i < 10; i++) begin
                if (sum < (1 << (mw + 3))) begin
                    sum = sum << 1;
                    e--;
                end
            end
        end
        keep = sum >> 3;
        rem  = sum & 7;
        if (rem > 4 || (rem == 4 && (keep & 1) != 0)) keep++;
        if (keep == (1 << (mw + 1))) begin
            keep = keep >> 1;
            e++;
        end
        return fp8_pack(x[7], e, keep, ew, mw);
    endfunction

endpackage

// File: rtl/fane_mac_vec_tree.sv
// Registered FP8 adder tree: log2(LANES) levels, one register per level, with a valid bit and sideband tag.
module fane_fp8_add_tree
    import fane_mac_pkg::*;
#(
    parameter int EXP_WIDTH  = 4,
    parameter int MANT_WIDTH = 3,
    parameter int LANES      = 4,
    parameter int TAG_W      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [LANES*FP8_W-1:0] in_data,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    output logic [FP8_W-1:0]       out_sum,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int LEVELS = clog2(LANES);
    localparam int NODES  = (LANES > 1) ? LANES - 1 : 1;
    localparam int VW     = (LEVELS > 0) ? LEVELS : 1;

    logic [NODES*FP8_W-1:0]         node_q;
    logic [VW-1:0]                  vld_q;
    logic [VW*TAG_W-1:0]            tag_q;
    logic [(LANES+NODES)*FP8_W-1:0] all_nodes;
    logic [VW:0]                    vld_chain;
    logic [(VW+1)*TAG_W-1:0]        tag_chain;

    // Leaves and registered sums share one index space: level k starts at 2*LANES - (2*LANES >> k)
    assign all_nodes = {node_q, in_data};
    assign vld_chain = {vld_q, in_valid};
    assign tag_chain = {tag_q, in_tag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_q <= '0;
            vld_q  <= '0;
            tag_q  <= '0;
        end else if (ce) begin
            for (int k = 1; k <= LEVELS; k++) begin
                vld_q[k-1] <= clear ? 1'b0 : vld_chain[k-1];
                tag_q[(k-1)*TAG_W +: TAG_W] <= tag_chain[(k-1)*TAG_W +: TAG_W];
                for (int i = 0; i < (LANES >> k); i++) begin
                    node_q[(LANES - ((2 * LANES) >> k) + i) * FP8_W +: FP8_W] <= fp8_add(
                        all_nodes[(2 * LANES - ((2 * LANES) >> (k - 1)) + 2 * i) * FP8_W +: FP8_W],
                        all_nodes[(2 * LANES - ((2 * LANES) >> (k - 1)) + 2 * i + 1) * FP8_W +: FP8_W],
                        EXP_WIDTH, MANT_WIDTH);
                end
            end
        end
    end

    if (LEVELS == 0) begin : g_pass
        assign out_valid = in_valid;
        assign out_sum   = in_data[FP8_W-1:0];
        assign out_tag   = in_tag;
    end else begin : g_tree
        assign out_valid = vld_q[LEVELS-1];
        assign out_sum   = node_q[(NODES-1)*FP8_W +: FP8_W];
        assign out_tag   = tag_q[(LEVELS-1)*TAG_W +: TAG_W];
    end

endmodule

// File: rtl/fane_mac_vec.sv
// FANE FP8 vector MAC: LANES-wide dot product with cascade (mode 0) or local group accumulation (mode 1).
// Optional FANE_MAC_RELU_EN clamps negative results to zero at the output register only.
module fane_mac_vec
    import fane_mac_pkg::*;
#(
    parameter int EXP_WIDTH  = 4,
    parameter int MANT_WIDTH = 3,
    parameter int LANES      = 4,
    parameter int ACC_LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [LANES*FP8_W-1:0] in_a,
    input  logic [LANES*FP8_W-1:0] in_b,
    input  logic [FP8_W-1:0]       cascade_sum_in,
    input  logic                   mode,
    input  logic [ACC_LEN_W-1:0]   acc_len,
    output logic                   out_valid,
    output logic [FP8_W-1:0]       acc_out,
    output logic [LANES*FP8_W-1:0] cascade_a_out,
    output logic [LANES*FP8_W-1:0] cascade_b_out,
    output logic                   busy
);

    localparam int TAG_W   = FP8_W + 3;
    localparam int T_LAST  = FP8_W;
    localparam int T_FIRST = FP8_W + 1;
    localparam int T_GRP   = FP8_W + 2;

    state_t                 state;
    logic [ACC_LEN_W-1:0]   count, grp_len, eff_len;
    logic [4:0]             inflight, inflight_next;
    logic                   first_n, last_n, grp_n, started, done;

    logic [LANES*FP8_W-1:0] a_q, b_q, prod1, prod2;
    logic                   v0, v1, v2;
    logic [TAG_W-1:0]       tag0, tag1, tag2;

    logic                   tv;
    logic [FP8_W-1:0]       tsum, acc, sum_n;
    logic [TAG_W-1:0]       ttag;

    assign cascade_a_out = a_q;
    assign cascade_b_out = b_q;

    // Group bookkeeping is decided at entry and carried down the pipe as first/last/grp flags
    assign eff_len = (acc_len == '0) ? ACC_LEN_W'(1) : acc_len;
    assign first_n = (state == IDLE);
    assign grp_n   = (state == ACC) || mode;
    assign last_n  = (state == IDLE) ? (!mode || eff_len == ACC_LEN_W'(1))
                                     : (ACC_LEN_W'(count + 1'b1) == grp_len);
    assign started = in_valid && (state == IDLE) && mode;
    assign done    = tv && ttag[T_LAST] && ttag[T_GRP];
    assign inflight_next = inflight + 5'(started) - 5'(done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            grp_len  <= '0;
            inflight <= '0;
            busy     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            v0       <= 1'b0;
            tag0     <= '0;
        end else if (ce) begin
            a_q <= in_a;
            b_q <= in_b;
            if (clear) begin
                state    <= IDLE;
                count    <= '0;
                inflight <= '0;
                busy     <= 1'b0;
                v0       <= 1'b0;
                tag0     <= '0;
            end else begin
                v0       <= in_valid;
                tag0     <= {grp_n, first_n, last_n, cascade_sum_in};
                inflight <= inflight_next;
                busy     <= (inflight_next != '0);
                if (in_valid) begin
                    if (state == IDLE) grp_len <= eff_len;
                    if (last_n) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        state <= ACC;
                        count <= count + 1'b1;
                    end
                end
            end
        end
    end

    // Two-stage lane multiply; sideband tag travels alongside so cascade_sum_in stays aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod1 <= '0;
            prod2 <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            tag1  <= '0;
            tag2  <= '0;
        end else if (ce) begin
            v1    <= clear ? 1'b0 : v0;
            v2    <= clear ? 1'b0 : v1;
            tag1  <= tag0;
            tag2  <= tag1;
            prod2 <= prod1;
            for (int i = 0; i < LANES; i++) begin
                prod1[i*FP8_W +: FP8_W] <= fp8_mul(a_q[i*FP8_W +: FP8_W], b_q[i*FP8_W +: FP8_W],
                                                   EXP_WIDTH, MANT_WIDTH);
            end
        end
    end

    fane_fp8_add_tree #(
        .EXP_WIDTH (EXP_WIDTH),
        .MANT_WIDTH(MANT_WIDTH),
        .LANES     (LANES),
        .TAG_W     (TAG_W)
    ) u_tree (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .clear    (clear),
        .in_valid (v2),
        .in_data  (prod2),
        .in_tag   (tag2),
        .out_valid(tv),
        .out_sum  (tsum),
        .out_tag  (ttag)
    );

    assign sum_n = ttag[T_FIRST] ? fp8_add(tsum, ttag[FP8_W-1:0], EXP_WIDTH, MANT_WIDTH)
                                 : fp8_add(acc, tsum, EXP_WIDTH, MANT_WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            if (clear) begin
                acc       <= '0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= tv && ttag[T_LAST];
                if (tv) begin
                    acc <= sum_n;
                    if (ttag[T_LAST]) begin
`ifdef FANE_MAC_RELU_EN
                        acc_out <= sum_n[FP8_W-1] ? FP8_ZERO : sum_n;
`else
                        acc_out <= sum_n;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fane_mac_vec.sv
// Directed self-checking bench for fane_mac_vec (E4M3, LANES=4, latency 6).
module tb_fane_mac_vec;

    logic        clk = 1'b0;
    logic        rst_n, ce, clear, in_valid, mode;
    logic [31:0] in_a, in_b;
    logic [7:0]  cascade_sum_in, acc_len;
    logic        out_valid, busy;
    logic [7:0]  acc_out;
    logic [31:0] cascade_a_out, cascade_b_out;

    int          vectors_applied = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          pulse_cyc = 0;
    logic [7:0]  pulse_data = 8'h00;
    int          c0, p0;

    fane_mac_vec dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_a          (in_a),
        .in_b          (in_b),
        .cascade_sum_in(cascade_sum_in),
        .mode          (mode),
        .acc_len       (acc_len),
        .out_valid     (out_valid),
        .acc_out       (acc_out),
        .cascade_a_out (cascade_a_out),
        .cascade_b_out (cascade_b_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: samples 1 ns after each rising edge and logs every out_valid cycle
    always @(posedge clk) begin
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            pulses++;
            pulse_cyc  = cyc;
            pulse_data = acc_out;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic [7:0] cs);
        in_valid       = 1'b1;
        in_a           = a;
        in_b           = b;
        cascade_sum_in = cs;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors_applied++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; clear = 1'b0; in_valid = 1'b0; mode = 1'b0;
        in_a = '0; in_b = '0; cascade_sum_in = '0; acc_len = 8'd1;
        step(2);
        check_output("reset acc_out", 32'(acc_out), 32'h0);
        check_output("reset out_valid", 32'(out_valid), 32'h0);
        check_output("reset busy", 32'(busy), 32'h0);
        check_output("reset cascade_a", cascade_a_out, 32'h0);
        rst_n = 1'b1;
        step(2);

        $display("[TB] mode 0 single vector");
        mode = 1'b0; c0 = cyc; p0 = pulses;
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        check_output("cascade_a_out", cascade_a_out, 32'h38383838);
        check_output("cascade_b_out", cascade_b_out, 32'h38383838);
        step(8);
        check_output("m0 pulse count", 32'(pulses - p0), 32'd1);
        check_output("m0 latency", 32'(pulse_cyc - c0), 32'd6);
        check_output("m0 acc_out", 32'(pulse_data), 32'h48);

        $display("[TB] mode 0 with nonzero cascade input");
        c0 = cyc; p0 = pulses;
        apply_stimulus(32'h40404040, 32'h38383838, 8'h48);
        step(8);
        check_output("m0 cascade pulses", 32'(pulses - p0), 32'd1);
        check_output("m0 cascade acc_out", 32'(pulse_data), 32'h54);

        $display("[TB] mode 1 acc_len=3");
        mode = 1'b1; acc_len = 8'd3; c0 = cyc; p0 = pulses;
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        check_output("m1 busy after first", 32'(busy), 32'h1);
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        step(4);
        check_output("m1 busy before pulse", 32'(busy), 32'h1);
        check_output("m1 no early pulse", 32'(out_valid), 32'h0);
        step(1);
        check_output("m1 pulse", 32'(out_valid), 32'h1);
        check_output("m1 busy at pulse", 32'(busy), 32'h0);
        check_output("m1 acc_out", 32'(acc_out), 32'h54);
        step(4);
        check_output("m1 pulse count", 32'(pulses - p0), 32'd1);

        $display("[TB] mode 1 acc_len=4 aborted by clear");
        acc_len = 8'd4; p0 = pulses;
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(10);
        check_output("clear no pulse", 32'(pulses - p0), 32'd0);
        check_output("clear busy", 32'(busy), 32'h0);
        check_output("clear holds acc_out", 32'(acc_out), 32'h54);
        acc_len = 8'd1; c0 = cyc; p0 = pulses;
        apply_stimulus(32'h38383838, 32'hB8B83838, 8'h00);
        step(7);
        check_output("len1 pulses", 32'(pulses - p0), 32'd1);
        check_output("len1 latency", 32'(pulse_cyc - c0), 32'd6);
        check_output("len1 cancel acc_out", 32'(pulse_data), 32'h00);

        $display("[TB] clear beats simultaneous in_valid");
        mode = 1'b0; p0 = pulses;
        in_a = 32'h38383838; in_b = 32'h38383838; cascade_sum_in = 8'h00;
        in_valid = 1'b1; clear = 1'b1;
        step(1);
        in_valid = 1'b0; clear = 1'b0;
        step(8);
        check_output("clear drop pulses", 32'(pulses - p0), 32'd0);

        $display("[TB] mode 1 acc_len=0 treated as 1");
        mode = 1'b1; acc_len = 8'd0; c0 = cyc; p0 = pulses;
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        check_output("len0 busy", 32'(busy), 32'h1);
        step(7);
        check_output("len0 pulses", 32'(pulses - p0), 32'd1);
        check_output("len0 latency", 32'(pulse_cyc - c0), 32'd6);
        check_output("len0 acc_out", 32'(pulse_data), 32'h48);
        check_output("len0 busy after", 32'(busy), 32'h0);

        $display("[TB] ce stall mid-flight");
        mode = 1'b0; acc_len = 8'd1; c0 = cyc; p0 = pulses;
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        step(1);
        ce = 1'b0;
        step(3);
        ce = 1'b1;
        step(8);
        check_output("ce pulses", 32'(pulses - p0), 32'd1);
        check_output("ce latency", 32'(pulse_cyc - c0), 32'd9);
        check_output("ce acc_out", 32'(pulse_data), 32'h48);

        $display("[TB] async reset mid-group");
        mode = 1'b1; acc_len = 8'd4;
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        step(2);
        check_output("pre-reset busy", 32'(busy), 32'h1);
        check_output("pre-reset acc_out", 32'(acc_out), 32'h48);
        rst_n = 1'b0;
        #1;
        check_output("rst acc_out", 32'(acc_out), 32'h0);
        check_output("rst busy", 32'(busy), 32'h0);
        check_output("rst out_valid", 32'(out_valid), 32'h0);
        check_output("rst cascade_b", cascade_b_out, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(1);
        acc_len = 8'd1; c0 = cyc; p0 = pulses;
        apply_stimulus(32'h38383838, 32'h38383838, 8'h00);
        step(8);
        check_output("post-rst pulses", 32'(pulses - p0), 32'd1);
        check_output("post-rst latency", 32'(pulse_cyc - c0), 32'd6);
        check_output("post-rst acc_out", 32'(pulse_data), 32'h48);

        $display("[TB] negative result");
        mode = 1'b0; p0 = pulses;
        apply_stimulus(32'h38383838, 32'hB8B8B8B8, 8'h00);
        step(8);
        check_output("neg pulses", 32'(pulses - p0), 32'd1);
`ifdef FANE_MAC_RELU_EN
        check_output("neg relu acc_out", 32'(pulse_data), 32'h00);
`else
        check_output("neg raw acc_out", 32'(pulse_data), 32'hC8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
